// File: rtl/irig_lock_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// irig_lock_ctrl_pkg
// Shared definitions for the IRIG-B lock supervisor.
//   - Decoder state codes reported by irig_state on its state output.
//   - Lock FSM state encoding, also exported on lock_state for debug.
//   - Field length in data symbols between two position marks.
//   - Small saturating-increment and strobe-collision helpers.
// -----------------------------------------------------------------------------
package irig_lock_ctrl_pkg;

    // Decoder state codes (irig_state)
    localparam logic [3:0] ST_UNLOCKED = 4'd0;
    localparam logic [3:0] ST_START    = 4'd2;
    localparam logic [3:0] ST_SECOND   = 4'd3;

    // Data symbols expected between two consecutive position marks
    localparam logic [3:0] IRIG_BITS_PER_FIELD = 4'd9;

    // Lock supervisor FSM
    typedef enum logic [2:0] {
        S_RESYNC  = 3'd0,
        S_ACQUIRE = 3'd1,
        S_VERIFY  = 3'd2,
        S_LOCKED  = 3'd3
    } lock_state_t;

    // 16-bit increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // 4-bit increment that sticks at all-ones
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // True when two or more symbol strobes fire in the same cycle
    function automatic logic multi_strobe(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/irig_sym_timer.sv
// -----------------------------------------------------------------------------
// irig_sym_timer
// Saturating cycle counter measuring the time since the last symbol strobe.
// The counter is reloaded to zero by i_clear and otherwise advances on i_tick,
// holding once it reaches TIMEOUT. o_expired flags the cycle in which the
// count would reach (or already sits at) TIMEOUT, so a clear in the same cycle
// suppresses it.
// Ports:
//   i_clk      system clock
//   i_rst      synchronous reset, active high
//   i_clear    reload counter to zero (symbol seen / supervisor idle)
//   i_tick     advance counter by one
//   o_expired  count reaches TIMEOUT on this cycle
// -----------------------------------------------------------------------------
module irig_sym_timer #(
    parameter int TIMEOUT = 2_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expired
);

    localparam int             W     = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]   LIMIT = W'(TIMEOUT);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_next;

    // Next count: clear wins, then saturating advance
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_clear) begin
            w_cnt_next = '0;
        end else if (i_tick && (r_cnt != LIMIT)) begin
            w_cnt_next = r_cnt + W'(1);
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    assign o_expired = (w_cnt_next == LIMIT);

    // Counter register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/irig_lock_ctrl.sv
// -----------------------------------------------------------------------------
// irig_lock_ctrl
// Lock supervisor for the IRIG-B decode chain. Watches symbol strobes, the
// decoder state and frame-complete strobe; resets the decoder on loss of
// signal or misalignment, qualifies lock over LOCK_FRAMES good frames, counts
// bad frames and gates PPS / timestamp-valid to the system.
// Ports:
//   i_clk          system clock
//   i_rst          synchronous reset, active high
//   i_irig_d0      1-cycle strobe, ZERO symbol
//   i_irig_d1      1-cycle strobe, ONE symbol
//   i_irig_mark    1-cycle strobe, MARK symbol
//   i_dec_state    decoder state (irig_state)
//   i_ts_finish    decoder frame-complete strobe
//   i_pps_gate     decoder PPS gate
//   o_dec_rst      synchronous reset to the decoder
//   o_locked       high while in S_LOCKED
//   o_pps_out      pps gate qualified by lock, registered
//   o_ts_valid     frame-complete qualified by lock and a clean frame
//   o_err_cnt      saturating count of bad frames since reset
//   o_lock_state   FSM state for debug
// -----------------------------------------------------------------------------
module irig_lock_ctrl
    import irig_lock_ctrl_pkg::*;
#(
    parameter int SYM_TIMEOUT   = 2_000_000,
    parameter int LOCK_FRAMES   = 2,
    parameter int UNLOCK_FRAMES = 3,
    parameter int DEC_RST_CYC   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_irig_d0,
    input  logic        i_irig_d1,
    input  logic        i_irig_mark,
    input  logic [3:0]  i_dec_state,
    input  logic        i_ts_finish,
    input  logic        i_pps_gate,
    output logic        o_dec_rst,
    output logic        o_locked,
    output logic        o_pps_out,
    output logic        o_ts_valid,
    output logic [15:0] o_err_cnt,
    output logic [2:0]  o_lock_state
);

    localparam logic [3:0]  LOCK_TARGET   = 4'(LOCK_FRAMES);
    localparam logic [3:0]  UNLOCK_TARGET = 4'(UNLOCK_FRAMES);
    localparam logic [15:0] PULSE_LOAD    = 16'(DEC_RST_CYC - 1);

    lock_state_t r_state;
    logic [15:0] r_pulse_cnt;
    logic [3:0]  r_good_cnt;
    logic [3:0]  r_bad_cnt;
    logic [3:0]  r_sym_cnt;
    logic        r_frame_err;
    logic [15:0] r_err_cnt;
    logic        r_dec_rst;
    logic        r_locked;
    logic        r_pps_out;
    logic        r_ts_valid;

    logic w_data;
    logic w_strobe_any;
    logic w_checking;
    logic w_spacing_err;
    logic w_multi;
    logic w_err_now;
    logic w_frame_bad;
    logic w_drop;
    logic w_tmr_clear;
    logic w_tmr_expired;
    logic w_timeout;
    logic w_go_resync;
    logic w_err_inc;

    assign w_data       = i_irig_d0 | i_irig_d1;
    assign w_strobe_any = w_data | i_irig_mark;
    assign w_checking   = (r_state == S_VERIFY) | (r_state == S_LOCKED);

    // A mark must close a full field, except the Pr mark right after P0
    assign w_spacing_err = i_irig_mark
                         & (r_sym_cnt != IRIG_BITS_PER_FIELD)
                         & ~((r_sym_cnt == 4'd0) & (i_dec_state == ST_START));
    assign w_multi       = multi_strobe(i_irig_d0, i_irig_d1, i_irig_mark);
    assign w_err_now     = w_checking & (w_spacing_err | w_multi);
    // Error on the ts_finish cycle still belongs to the finishing frame
    assign w_frame_bad   = r_frame_err | w_err_now;

    assign w_drop      = (r_state != S_RESYNC) & (i_dec_state == ST_UNLOCKED);
    // Timer is held at zero during resync so acquisition starts with a fresh window
    assign w_tmr_clear = w_strobe_any | (r_state == S_RESYNC);
    assign w_timeout   = (r_state != S_RESYNC) & w_tmr_expired;

    // Bad frames and losses of signal only count against an established lock
    assign w_err_inc = (r_state == S_LOCKED) & ~w_drop
                     & (w_timeout | (i_ts_finish & w_frame_bad));

    irig_sym_timer #(
        .TIMEOUT (SYM_TIMEOUT)
    ) u_sym_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_tmr_clear),
        .i_tick    (1'b1),
        .o_expired (w_tmr_expired)
    );

    // Decide whether this cycle forces the supervisor back to resync
    always_comb begin
        w_go_resync = 1'b0;
        case (r_state)
            S_RESYNC:  w_go_resync = 1'b0;
            S_ACQUIRE: w_go_resync = w_drop | w_timeout;
            S_VERIFY:  w_go_resync = w_drop | w_timeout | w_err_now
                                   | (i_ts_finish & w_frame_bad);
            S_LOCKED:  w_go_resync = w_drop | w_timeout
                                   | (i_ts_finish & w_frame_bad
                                      & ((r_bad_cnt + 4'd1) == UNLOCK_TARGET));
            default:   w_go_resync = 1'b1;
        endcase
    end

    // Data symbols seen since the last mark
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sym_cnt <= 4'd0;
        end else if ((r_state == S_RESYNC) || i_irig_mark) begin
            r_sym_cnt <= 4'd0;
        end else if (w_data) begin
            r_sym_cnt <= sat_inc4(r_sym_cnt);
        end else begin
            r_sym_cnt <= r_sym_cnt;
        end
    end

    // Sticky per-frame error flag, consumed by ts_finish
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_err <= 1'b0;
        end else if (!w_checking || i_ts_finish) begin
            r_frame_err <= 1'b0;
        end else if (w_err_now) begin
            r_frame_err <= 1'b1;
        end else begin
            r_frame_err <= r_frame_err;
        end
    end

    // Saturating bad-frame counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_cnt <= 16'd0;
        end else if (w_err_inc) begin
            r_err_cnt <= sat_inc16(r_err_cnt);
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    // Lock FSM with its registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_RESYNC;
            r_pulse_cnt <= PULSE_LOAD;
            r_good_cnt  <= 4'd0;
            r_bad_cnt   <= 4'd0;
            r_dec_rst   <= 1'b1;
            r_locked    <= 1'b0;
            r_pps_out   <= 1'b0;
            r_ts_valid  <= 1'b0;
        end else begin
            r_pps_out  <= i_pps_gate & (r_state == S_LOCKED);
            r_ts_valid <= i_ts_finish & ~w_frame_bad & (r_state == S_LOCKED)
                        & ~w_drop & ~w_timeout;
            if (w_go_resync) begin
                r_state     <= S_RESYNC;
                r_pulse_cnt <= PULSE_LOAD;
                r_good_cnt  <= 4'd0;
                r_bad_cnt   <= 4'd0;
                r_dec_rst   <= 1'b1;
                r_locked    <= 1'b0;
            end else begin
                case (r_state)
                    S_RESYNC: begin
                        if (r_pulse_cnt == 16'd0) begin
                            r_state   <= S_ACQUIRE;
                            r_dec_rst <= 1'b0;
                        end else begin
                            r_pulse_cnt <= r_pulse_cnt - 16'd1;
                        end
                    end
                    S_ACQUIRE: begin
                        if (i_dec_state == ST_SECOND) begin
                            r_state <= S_VERIFY;
                        end else begin
                            r_state <= S_ACQUIRE;
                        end
                    end
                    S_VERIFY: begin
                        // Bad frames never get here: they already forced resync
                        if (i_ts_finish) begin
                            if ((r_good_cnt + 4'd1) == LOCK_TARGET) begin
                                r_state    <= S_LOCKED;
                                r_locked   <= 1'b1;
                                r_good_cnt <= 4'd0;
                            end else begin
                                r_good_cnt <= r_good_cnt + 4'd1;
                            end
                        end else begin
                            r_good_cnt <= r_good_cnt;
                        end
                    end
                    S_LOCKED: begin
                        if (i_ts_finish) begin
                            r_bad_cnt <= w_frame_bad ? sat_inc4(r_bad_cnt) : 4'd0;
                        end else begin
                            r_bad_cnt <= r_bad_cnt;
                        end
                    end
                    default: begin
                        r_state     <= S_RESYNC;
                        r_pulse_cnt <= PULSE_LOAD;
                        r_dec_rst   <= 1'b1;
                        r_locked    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_dec_rst    = r_dec_rst;
    assign o_locked     = r_locked;
    assign o_pps_out    = r_pps_out;
    assign o_ts_valid   = r_ts_valid;
    assign o_err_cnt    = r_err_cnt;
    assign o_lock_state = r_state;

endmodule

// File: tb/tb_irig_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irig_lock_ctrl
// Directed bench for the IRIG-B lock supervisor (SYM_TIMEOUT shortened to 1000).
// Expected output bundles {dec_rst, locked, pps_out, ts_valid, err_cnt, state}
// are queued as stimulus is driven and compared when the DUT has responded.
// -----------------------------------------------------------------------------
module tb_irig_lock_ctrl;
    import irig_lock_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        d0, d1, mark;
    logic [3:0]  dec_state;
    logic        ts_finish;
    logic        pps_gate;
    logic        dec_rst, locked, pps_out, ts_valid;
    logic [15:0] err_cnt;
    logic [2:0]  lock_state;

    typedef struct {
        string       tag;
        logic [22:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    irig_lock_ctrl #(
        .SYM_TIMEOUT   (1000),
        .LOCK_FRAMES   (2),
        .UNLOCK_FRAMES (3),
        .DEC_RST_CYC   (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_irig_d0    (d0),
        .i_irig_d1    (d1),
        .i_irig_mark  (mark),
        .i_dec_state  (dec_state),
        .i_ts_finish  (ts_finish),
        .i_pps_gate   (pps_gate),
        .o_dec_rst    (dec_rst),
        .o_locked     (locked),
        .o_pps_out    (pps_out),
        .o_ts_valid   (ts_valid),
        .o_err_cnt    (err_cnt),
        .o_lock_state (lock_state)
    );

    function automatic logic [22:0] mk(input logic dr, input logic lk, input logic pp,
                                       input logic tv, input logic [15:0] ec,
                                       input logic [2:0] st);
        return {dr, lk, pp, tv, ec, st};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [22:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb_q.push_back(x);
    endtask

    task automatic chk();
        exp_t        x;
        logic [22:0] obs;
        x   = sb_q.pop_front();
        obs = {dec_rst, locked, pps_out, ts_valid, err_cnt, lock_state};
        n_cmp++;
        assert (obs === x.exp) else begin
            n_fail++;
            $error("FAIL %s: observed {dr,lk,pps,tv,err,st}=%b,%b,%b,%b,%h,%0d expected %b,%b,%b,%b,%h,%0d",
                   x.tag, obs[22], obs[21], obs[20], obs[19], obs[18:3], obs[2:0],
                   x.exp[22], x.exp[21], x.exp[20], x.exp[19], x.exp[18:3], x.exp[2:0]);
        end
    endtask

    // queue an expectation, advance one clock, compare
    task automatic expect_step(input string tag, input logic [22:0] e);
        push(tag, e);
        step();
        chk();
    endtask

    // kind: 0=ZERO, 1=ONE, 2=MARK; one strobe cycle plus one idle cycle
    task automatic sym(input int kind);
        d0   = (kind == 0);
        d1   = (kind == 1);
        mark = (kind == 2);
        step();
        d0   = 1'b0;
        d1   = 1'b0;
        mark = 1'b0;
        step();
    endtask

    task automatic data_bits(input int n);
        for (int i = 0; i < n; i++) sym(i % 2);
    endtask

    // reference mark following P0
    task automatic pr_mark();
        dec_state = ST_START;
        sym(2);
        dec_state = ST_SECOND;
    endtask

    // frame-complete strobe with the expected outputs right after it
    task automatic end_frame(input string tag, input logic [22:0] e);
        ts_finish = 1'b1;
        expect_step(tag, e);
        ts_finish = 1'b0;
    endtask

    // park the decoder in a searching state and let the resync pulse finish
    task automatic wait_acquire();
        dec_state = 4'd1;
        repeat (4) step();
    endtask

    // from S_ACQUIRE: enter verify and deliver two clean frames
    task automatic relock(input logic [15:0] ec);
        dec_state = ST_SECOND;
        step();
        data_bits(9);
        sym(2);
        ts_finish = 1'b1;
        step();
        ts_finish = 1'b0;
        pr_mark();
        data_bits(9);
        sym(2);
        end_frame("relock", mk(1'b0, 1'b1, 1'b0, 1'b0, ec, 3'd3));
        pr_mark();
    endtask

    initial begin
        rst       = 1'b1;
        d0        = 1'b0;
        d1        = 1'b0;
        mark      = 1'b0;
        dec_state = 4'd1;
        ts_finish = 1'b0;
        pps_gate  = 1'b1;
        step();
        step();
        push("reset", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0));
        chk();

        // dec_rst stays high four decoder clocks after reset release
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            expect_step("rst_pulse", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0));
        expect_step("acquire", mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd1));

        dec_state = ST_SECOND;
        expect_step("verify_entry", mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd2));

        // two clean frames -> lock one cycle after the second ts_finish
        data_bits(9);
        sym(2);
        end_frame("frame1", mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3'd2));
        pr_mark();
        data_bits(9);
        sym(2);
        end_frame("lock_rise", mk(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 3'd3));
        expect_step("pps_follow", mk(1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 3'd3));
        pr_mark();

        // clean locked frame -> single-cycle ts_valid; pps follows the gate
        data_bits(9);
        sym(2);
        end_frame("ts_valid", mk(1'b0, 1'b1, 1'b1, 1'b1, 16'd0, 3'd3));
        expect_step("ts_valid_1cyc", mk(1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 3'd3));
        pps_gate = 1'b0;
        expect_step("pps_gate_low", mk(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 3'd3));
        pps_gate = 1'b1;
        pr_mark();

        // 8 data bits between marks -> counted, lock held, ts_valid suppressed
        data_bits(8);
        sym(2);
        end_frame("short_field", mk(1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 3'd3));
        pr_mark();
        data_bits(9);
        sym(2);
        end_frame("good_after_bad", mk(1'b0, 1'b1, 1'b1, 1'b1, 16'd1, 3'd3));
        pr_mark();

        // three consecutive bad frames -> unlock
        data_bits(8);
        mark      = 1'b1;
        ts_finish = 1'b1;
        expect_step("err_on_finish", mk(1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 3'd3));
        mark      = 1'b0;
        ts_finish = 1'b0;
        step();
        pr_mark();
        data_bits(8);
        d0 = 1'b1;
        d1 = 1'b1;
        step();
        d0 = 1'b0;
        d1 = 1'b0;
        step();
        sym(2);
        end_frame("multi_strobe", mk(1'b0, 1'b1, 1'b1, 1'b0, 16'd3, 3'd3));
        pr_mark();
        data_bits(8);
        sym(2);
        dec_state = 4'd1;
        end_frame("unlock", mk(1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 3'd0));
        expect_step("pps_drop", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 3'd0));
        for (int i = 0; i < 2; i++)
            expect_step("resync_len", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 3'd0));
        expect_step("resync_end", mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 3'd1));

        // loss of signal: strobe on cycle 1000 saves it, silence does not
        relock(16'd4);
        repeat (998) step();
        d0 = 1'b1;
        expect_step("strobe_at_limit", mk(1'b0, 1'b1, 1'b1, 1'b0, 16'd4, 3'd3));
        d0 = 1'b0;
        repeat (998) step();
        expect_step("pre_timeout", mk(1'b0, 1'b1, 1'b1, 1'b0, 16'd4, 3'd3));
        expect_step("timeout", mk(1'b1, 1'b0, 1'b1, 1'b0, 16'd5, 3'd0));
        wait_acquire();

        // decoder drop while verifying -> resync, no error count
        dec_state = ST_SECOND;
        expect_step("verify_again", mk(1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 3'd2));
        dec_state = ST_UNLOCKED;
        expect_step("drop_verify", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 3'd0));
        wait_acquire();

        // drop together with ts_finish while locked -> no ts_valid
        relock(16'd5);
        data_bits(9);
        sym(2);
        dec_state = ST_UNLOCKED;
        end_frame("drop_with_finish", mk(1'b1, 1'b0, 1'b1, 1'b0, 16'd5, 3'd0));
        wait_acquire();

        // error counter saturation
        relock(16'd5);
        force dut.r_err_cnt = 16'hFFFE;
        #1;
        release dut.r_err_cnt;
        data_bits(8);
        sym(2);
        end_frame("sat_ffff", mk(1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 3'd3));
        pr_mark();
        data_bits(8);
        sym(2);
        end_frame("sat_hold", mk(1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 3'd3));
        pr_mark();

        // reset mid-frame
        data_bits(4);
        rst = 1'b1;
        expect_step("rst_mid", mk(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0));
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
